// File: rtl/maxnet_pkg.sv
// Shared types and default constants for the Maxnet winner-take-all control slice.
package maxnet_pkg;

  localparam int MAXNET_DATA_W  = 32;
  localparam int MAXNET_MAX_ITER = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_WAIT_PU,
    ST_UPDATE,
    ST_RESULT
  } maxnet_state_t;

endpackage

// File: rtl/maxnet_result_buffer.sv
// Holds the winner value and its timeout flag until the downstream consumer accepts it.
// Latency: capture visible the cycle after the capture strobe; holds under backpressure until valid&ready.
module maxnet_result_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [DATA_W-1:0] cap_dat,
  input  logic              cap_timeout,
  input  logic              clr_timeout,
  input  logic              result_ready,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              timeout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result       <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
    end else if (capture) begin
      result       <= cap_dat;
      result_valid <= 1'b1;
      timeout      <= cap_timeout;
    end else begin
      if (result_valid && result_ready) result_valid <= 1'b0;
      if (clr_timeout) timeout <= 1'b0;
    end
  end

endmodule

// File: rtl/maxnet_controller.sv
// Sequences one Maxnet run: load x/t, iterate the Pu feedback loop, present the winner on valid/ready.
// Latency: >= 3 cycles start-to-valid; RESULT holds until result_ready. MAXNET_CTRL_TIMEOUT_EN enables the MAX_ITER limit.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int DATA_W     = MAXNET_DATA_W,
  parameter int PU_LATENCY = 2,
  parameter int MAX_ITER   = MAXNET_MAX_ITER,
  parameter int ITER_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              ld_x,
  output logic              ld_t,
  output logic              sel_t,
  input  logic              done_dp,
  input  logic [DATA_W-1:0] max_in,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

`ifdef MAXNET_CTRL_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  maxnet_state_t state;
  logic [3:0]    pu_cnt;
  logic          hit_limit;
  logic          capture;
  logic          cap_timeout;
  logic          clr_timeout;

  // With the limit disabled this folds to 0, so CHECK leaves only on done_dp.
  assign hit_limit   = TIMEOUT_EN && (iter_count == ITER_LIMIT);
  assign capture     = (state == ST_CHECK) && (done_dp || hit_limit);
  assign cap_timeout = !done_dp && hit_limit;
  assign clr_timeout = (state == ST_IDLE) && start;

  // Strobes are registered alongside the next state so they never see an input path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      ld_x       <= 1'b0;
      ld_t       <= 1'b0;
      sel_t      <= 1'b0;
      iter_count <= '0;
      pu_cnt     <= '0;
    end else begin
      ld_x  <= 1'b0;
      ld_t  <= 1'b0;
      sel_t <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_LOAD;
            busy       <= 1'b1;
            ld_x       <= 1'b1;
            ld_t       <= 1'b1;
            sel_t      <= 1'b1;
            iter_count <= '0;
          end
        end
        ST_LOAD: state <= ST_CHECK;
        ST_CHECK: begin
          if (done_dp || hit_limit) begin
            state <= ST_RESULT;
          end else if (PU_LATENCY == 0) begin
            state <= ST_UPDATE;
            ld_t  <= 1'b1;
          end else begin
            state  <= ST_WAIT_PU;
            pu_cnt <= 4'(PU_LATENCY - 1);
          end
        end
        ST_WAIT_PU: begin
          if (pu_cnt == 4'd0) begin
            state <= ST_UPDATE;
            ld_t  <= 1'b1;
          end else begin
            pu_cnt <= pu_cnt - 4'd1;
          end
        end
        ST_UPDATE: begin
          state <= ST_CHECK;
          if (iter_count != '1) iter_count <= iter_count + ITER_W'(1);
        end
        ST_RESULT: begin
          if (result_valid && result_ready) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  maxnet_result_buffer #(
    .DATA_W(DATA_W)
  ) u_result_buffer (
    .clk          (clk),
    .rst          (rst),
    .capture      (capture),
    .cap_dat      (max_in),
    .cap_timeout  (cap_timeout),
    .clr_timeout  (clr_timeout),
    .result_ready (result_ready),
    .result       (result),
    .result_valid (result_valid),
    .timeout      (timeout)
  );

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller with PU_LATENCY=2 and MAX_ITER=4.
module tb_maxnet_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        done_dp = 1'b0;
  logic        result_ready = 1'b0;
  logic [31:0] max_in = '0;
  logic        busy, ld_x, ld_t, sel_t, result_valid, timeout;
  logic [31:0] result;
  logic [7:0]  iter_count;

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  maxnet_controller #(
    .DATA_W(32), .PU_LATENCY(2), .MAX_ITER(4), .ITER_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .ld_x(ld_x), .ld_t(ld_t), .sel_t(sel_t), .done_dp(done_dp),
    .max_in(max_in), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .timeout(timeout), .iter_count(iter_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] upd_mask;
    logic        early_valid;
    logic        got;
    int          n_upd;

    // Reset held: start toggling must not wake anything up.
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      tick();
    end
    chk("rst_ctrl", {busy, ld_x, ld_t, sel_t, result_valid, timeout}, 64'd0);
    chk("rst_data", {result, iter_count}, 64'd0);
    start = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_strobes", {busy, ld_x, ld_t, sel_t}, 64'd0);
    end

    // Immediate done with zero-wait handshake, then restart in the IDLE cycle.
    max_in = 32'h0000_0040;
    result_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_strobes", {busy, ld_x, ld_t, sel_t}, 64'b1111);
    tick();
    chk("check_strobes", {busy, ld_x, ld_t, sel_t, result_valid}, 64'b10000);
    done_dp = 1'b1;
    tick();
    chk("imm_valid", {busy, result_valid, timeout}, 64'b110);
    chk("imm_result", result, 64'h40);
    chk("imm_iter", iter_count, 64'd0);
    start = 1'b1;
    tick();
    chk("imm_pulse_end", {busy, result_valid}, 64'd0);
    tick();
    start = 1'b0;
    chk("restart_load", {busy, ld_x, ld_t, sel_t}, 64'b1111);
    tick();
    tick();
    chk("restart_result", result_valid, 64'd1);
    tick();
    chk("restart_idle", busy, 64'd0);
    done_dp = 1'b0;
    result_ready = 1'b0;

    // Three feedback iterations; done rises in cycle 14.
    max_in = 32'h0000_0077;
    start = 1'b1;
    upd_mask = '0;
    early_valid = 1'b0;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      tick();
      start = 1'b0;
      if (ld_t && !sel_t) upd_mask[cyc] = 1'b1;
      if (cyc < 15 && result_valid) early_valid = 1'b1;
      if (cyc == 14) done_dp = 1'b1;
    end
    chk("iter3_updates", upd_mask, 64'h2220);
    chk("iter3_no_early", early_valid, 64'd0);
    chk("iter3_valid", {result_valid, timeout}, 64'b10);
    chk("iter3_count", iter_count, 64'd3);
    chk("iter3_result", result, 64'h77);
    done_dp = 1'b0;

    // Backpressure: result must hold and start must not be queued.
    for (int k = 1; k <= 5; k++) begin
      max_in = $urandom;
      start = k[0];
      tick();
      chk("bp_hold", {result_valid, busy, ld_x, result}, {31'd0, 3'b110, 32'h77});
    end
    start = 1'b0;
    result_ready = 1'b1;
    tick();
    chk("bp_release", {busy, result_valid}, 64'd0);
    tick();
    chk("bp_no_queue", {busy, ld_x}, 64'd0);

`ifdef MAXNET_CTRL_TIMEOUT_EN
    // Iteration limit of 4 with done never asserted.
    start = 1'b1;
    n_upd = 0;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      tick();
      start = 1'b0;
      if (ld_t && !sel_t) n_upd++;
      if (result_valid) got = 1'b1;
    end
    chk("to_result", got, 64'd1);
    chk("to_updates", n_upd, 64'd4);
    chk("to_flag", timeout, 64'd1);
    chk("to_iter", iter_count, 64'd4);
`else
    // No limit: 300 updates, no result, counter pinned at all ones.
    start = 1'b1;
    n_upd = 0;
    got = 1'b0;
    for (int c = 0; c < 1400 && n_upd < 300; c++) begin
      tick();
      start = 1'b0;
      if (ld_t && !sel_t) n_upd++;
      if (result_valid) got = 1'b1;
    end
    chk("unb_updates", n_upd, 64'd300);
    chk("unb_no_result", {got, timeout}, 64'd0);
    chk("unb_saturate", iter_count, 64'd255);
`endif

    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Reset mid-run during the second WAIT_PU (cycle 7).
    max_in = 32'h0000_0123;
    start = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      tick();
      start = 1'b0;
    end
    chk("mid_pre", {busy, iter_count}, {55'd0, 1'b1, 8'd1});
    #2 rst = 1'b0;
    #1;
    chk("mid_async_ctrl", {busy, ld_x, ld_t, sel_t, result_valid, timeout}, 64'd0);
    chk("mid_async_iter", iter_count, 64'd0);
    #2 rst = 1'b1;
    tick();
    chk("post_rst_idle", {busy, result_valid}, 64'd0);

    // Clean run after reset: two updates, done in cycle 10.
    start = 1'b1;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      tick();
      start = 1'b0;
      if (cyc == 10) done_dp = 1'b1;
    end
    chk("post_valid", {result_valid, timeout}, 64'b10);
    chk("post_iter", iter_count, 64'd2);
    chk("post_result", result, 64'h123);
    done_dp = 1'b0;
    tick();
    chk("post_idle", {busy, result_valid}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/maxnet_controller.md
# maxnet_controller

Control stage directly upstream of the Maxnet datapath. It sequences one winner-take-all run: it loads the four memory words into the x and t registers, then iterates the Pu/activation feedback loop. It samples the datapath `done` flag after every t update and hands the selected `maximum_number` downstream through a valid/ready result buffer. Datapath registers load only on the `ld_x`, `ld_t` and `sel_t` strobes from this block.

## Interface
- `DATA_W`, 32: width of `max_in`/`result`.
- `PU_LATENCY`, 2: clock cycles from a t-register update until the Pu/activation outputs are valid; range 0–15.
- `MAX_ITER`, 64: iteration limit before timeout; range 1–255.
- `ITER_W`, 8: width of the iteration counter.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `busy`  out  1  high from LOAD through RESULT inclusive.
- `ld_x`  out  1  x-register load strobe to the datapath.
- `ld_t`  out  1  t-register load strobe to the datapath.
- `sel_t`  out  1  1 = t loads memory data; 0 = t loads activation outputs.
- `done_dp`  in  1  datapath done flag (at most one nonzero t).
- `max_in`  in  DATA_W  datapath `maximum_number`.
- `result`  out  DATA_W  captured winner value.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  downstream accept.
- `timeout`  out  1  last result was produced by the iteration limit, not by `done_dp`.
- `iter_count`  out  ITER_W  number of feedback updates in the current or last run.

## Operation
- States: IDLE, LOAD, CHECK, WAIT_PU, UPDATE, RESULT.
- IDLE: no strobes. `start`=1 → LOAD. Clears `iter_count` and `timeout` on exit.
- LOAD (1 cycle): `ld_x`=`ld_t`=`sel_t`=1 → CHECK.
- CHECK (1 cycle): `done_dp` has priority.
  - `done_dp`=1 → capture `max_in` into `result`; go to RESULT.
  - Else if `iter_count`==MAX_ITER → capture `max_in`, set `timeout`=1; go to RESULT.
  - Else → WAIT_PU, or UPDATE directly if PU_LATENCY=0.
- WAIT_PU: lasts exactly PU_LATENCY cycles, using a down-counter loaded in CHECK → UPDATE.
- UPDATE (1 cycle): `ld_t`=1, `sel_t`=0; `iter_count`+1, saturating at all ones → CHECK.
- RESULT: `result_valid`=1. `result` holds stable regardless of `max_in`. Transfer when `result_valid`&`result_ready` → IDLE.
- `start` outside IDLE is ignored, not queued.
- `sel_t` is 0 whenever `ld_t`=0.
- Strobes are decoded from the registered state only; they carry no combinational path from inputs.

## Timing
- Reset values: state IDLE; `busy`, `ld_x`, `ld_t`, `sel_t`, `result_valid`, `timeout` = 0; `result`, `iter_count` = 0.
- Reset is asynchronous: asserting `rst` mid-run forces all outputs to their reset values immediately. The run is discarded and no partial result is presented.
- `start` sampled at edge 0 → LOAD in cycle 1, first CHECK in cycle 2.
- First UPDATE in cycle 3+PU_LATENCY.
- UPDATE period is PU_LATENCY+2 cycles.
- RESULT is entered one cycle after the deciding CHECK.
- Minimum start-to-`result_valid` latency: 3 cycles.
- Zero-wait handshake: `result_ready`=1 on the first RESULT cycle → 1-cycle valid pulse; IDLE next cycle; a new `start` is accepted in that IDLE cycle.

## Configuration
- `MAXNET_CTRL_TIMEOUT_EN` defined:
  - MAX_ITER check is active.
  - `timeout` behaves as described above.
- `MAXNET_CTRL_TIMEOUT_EN` undefined:
  - CHECK leaves only on `done_dp`.
  - Iteration is unbounded.
  - `iter_count` saturates.
  - `timeout` is tied to 0.

## Structure
- Shared package `maxnet_pkg` holds:
  - the state enum `maxnet_state_t`;
  - the default constants `MAXNET_DATA_W`=32 and `MAXNET_MAX_ITER`=64.
- One sub-module, `maxnet_result_buffer`: DATA_W holding register with capture enable, valid/ready handshake and the timeout flag.

## Test plan
- Reset: hold `rst`=0, toggle `start` → all outputs 0, no strobes; release, idle 5 cycles → no strobes.
- Immediate done: PU_LATENCY=2, `done_dp`=1 from cycle 2, `max_in`=32'h0000_0040 → LOAD strobes in cycle 1, `result_valid`=1 in cycle 3, `result`=32'h40, `iter_count`=0, `timeout`=0.
- Three iterations: PU_LATENCY=2, `done_dp` rises in cycle 14 → `ld_t`=1, `sel_t`=0 in cycles 5, 9, 13; `result_valid` in cycle 15, `iter_count`=3.
- Backpressure: `result_ready`=0 for 5 RESULT cycles, `max_in` changes, `start` pulses → `result` unchanged, `result_valid` held, no new LOAD; `result_ready`=1 → IDLE next cycle.
- Timeout (macro defined, MAX_ITER=4, `done_dp`=0): exactly 4 UPDATE pulses, then `result_valid`=1, `timeout`=1, `iter_count`=4. With the macro undefined, no result after 100 updates.
- Reset mid-run: assert `rst` during WAIT_PU → `busy` and strobes drop without waiting for a clock edge; after release, a new `start` runs cleanly with `iter_count` from 0.
